// File: rtl/spi_wb_slave_regs.sv
`default_nettype none
// ============================================================================
// Module   : spi_wb_slave_regs
// Purpose  : Wishbone classic slave register bank of the SPI core. It decodes
//            single read/write cycles into the TX, CTRL, DIVIDER and SS
//            registers. It feeds those registers to the SPI shift engine and
//            returns RX data and completion status to the bus. It also
//            produces ack/err and a transfer-complete interrupt.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   CHAR_LEN_W : width of the CTRL character-length field (at most 7)
//   SS_W       : number of slave-select lines (at most 32)
// Ports
//   clk_in, rst_n_in        : clock, asynchronous active-low reset
//   adr_in[4:0]             : byte address, [4:2] selects the register
//   dat_in, sel_in, we_in   : write data, byte lanes, write enable
//   cyc_in, stb_in          : Wishbone cycle / strobe
//   dat_o, ack_o, err_o     : read data (0 outside ack), terminations
//   int_o                   : transfer-complete interrupt
//   tx_data_o               : TX3..TX0 (TX0 in [31:0])
//   char_len_o, rx_neg_o, tx_neg_o, lsb_o, ass_o : CTRL fields
//   divider_o, ss_o         : clock divider, slave-select register
//   go_o                    : one-cycle transfer start pulse
//   busy_in, done_in        : engine status (synchronous to clk_in)
//   rx_data_in              : engine RX shift register (RX0 in [31:0])
// Build option
//   SPI_WB_ERR_EN : when defined, accesses to address 7 and writes issued
//                   while busy (other than to SS) terminate with err_o.
// ============================================================================
module spi_wb_slave_regs #(
    parameter int CHAR_LEN_W = 7,
    parameter int SS_W       = 8
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic [4:0]            adr_in,
    input  logic [31:0]           dat_in,
    input  logic [3:0]            sel_in,
    input  logic                  we_in,
    input  logic                  cyc_in,
    input  logic                  stb_in,
    output logic [31:0]           dat_o,
    output logic                  ack_o,
    output logic                  err_o,
    output logic                  int_o,
    output logic [127:0]          tx_data_o,
    output logic [CHAR_LEN_W-1:0] char_len_o,
    output logic                  rx_neg_o,
    output logic                  tx_neg_o,
    output logic                  lsb_o,
    output logic                  ass_o,
    output logic [15:0]           divider_o,
    output logic [SS_W-1:0]       ss_o,
    output logic                  go_o,
    input  logic                  busy_in,
    input  logic                  done_in,
    input  logic [127:0]          rx_data_in
);

    localparam logic [2:0] c_ADR_CTRL = 3'd4;
    localparam logic [2:0] c_ADR_DIV  = 3'd5;
    localparam logic [2:0] c_ADR_SS   = 3'd6;
    localparam logic [2:0] c_ADR_NONE = 3'd7;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [3:0][31:0]      r_tx;
    logic [CHAR_LEN_W-1:0] r_char_len;
    logic                  r_go_bit;
    logic                  r_rx_neg;
    logic                  r_tx_neg;
    logic                  r_lsb;
    logic                  r_ie;
    logic                  r_ass;
    logic [15:0]           r_div;
    logic [SS_W-1:0]       r_ss;
    logic [31:0]           r_dat;
    logic                  r_ack;
    logic                  r_err;
    logic                  r_int;
    logic                  r_go_req;
    logic                  r_go_pulse;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic [2:0]  w_reg_sel;
    logic        w_accept;
    logic        w_err_case;
    logic        w_wr_any;
    logic        w_wr_core;
    logic        w_wr_ss;
    logic        w_go_set;
    logic [31:0] w_wmask;
    logic [31:0] w_rd_mux;
    logic        w_unused;

    assign w_reg_sel = adr_in[4:2];

    // A new request is only taken while no termination is being presented,
    // so a master holding stb high is served every second cycle.
    assign w_accept = cyc_in & stb_in & ~r_ack & ~r_err;

`ifdef SPI_WB_ERR_EN
    assign w_err_case = (w_reg_sel == c_ADR_NONE) |
                        (we_in & busy_in & (w_reg_sel != c_ADR_SS));
`else
    assign w_err_case = 1'b0;
`endif

    // Error-terminated accesses never modify state.
    assign w_wr_any  = w_accept & we_in & ~w_err_case;
    // TX, CTRL and DIVIDER are frozen while the engine is shifting.
    assign w_wr_core = w_wr_any & ~busy_in;
    assign w_wr_ss   = w_wr_any & (w_reg_sel == c_ADR_SS);
    assign w_go_set  = w_wr_core & (w_reg_sel == c_ADR_CTRL) & sel_in[1] & dat_in[8];

    assign w_wmask = {{8{sel_in[3]}}, {8{sel_in[2]}}, {8{sel_in[1]}}, {8{sel_in[0]}}};

    // The low address bits carry no information for word registers.
    assign w_unused = &{1'b0, adr_in[1:0]};

    always_comb begin
        w_rd_mux = '0;
        case (w_reg_sel)
            3'd0:       w_rd_mux = rx_data_in[31:0];
            3'd1:       w_rd_mux = rx_data_in[63:32];
            3'd2:       w_rd_mux = rx_data_in[95:64];
            3'd3:       w_rd_mux = rx_data_in[127:96];
            c_ADR_CTRL: begin
                w_rd_mux[CHAR_LEN_W-1:0] = r_char_len;
                w_rd_mux[8]              = r_go_bit;
                w_rd_mux[9]              = r_rx_neg;
                w_rd_mux[10]             = r_tx_neg;
                w_rd_mux[11]             = r_lsb;
                w_rd_mux[12]             = r_ie;
                w_rd_mux[13]             = r_ass;
            end
            c_ADR_DIV:  w_rd_mux[15:0]   = r_div;
            c_ADR_SS:   w_rd_mux[SS_W-1:0] = r_ss;
            default:    w_rd_mux = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_tx       <= '0;
            r_char_len <= '0;
            r_go_bit   <= 1'b0;
            r_rx_neg   <= 1'b0;
            r_tx_neg   <= 1'b0;
            r_lsb      <= 1'b0;
            r_ie       <= 1'b0;
            r_ass      <= 1'b0;
            r_div      <= '0;
            r_ss       <= '0;
            r_dat      <= '0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_int      <= 1'b0;
            r_go_req   <= 1'b0;
            r_go_pulse <= 1'b0;
        end else begin
            r_ack <= w_accept & ~w_err_case;
            r_err <= w_accept & w_err_case;
            // Read data is only non-zero during a read acknowledge.
            r_dat <= (w_accept & ~we_in & ~w_err_case) ? w_rd_mux : 32'h0;

            if (w_wr_core && !w_reg_sel[2]) begin
                r_tx[w_reg_sel[1:0]] <= (r_tx[w_reg_sel[1:0]] & ~w_wmask) |
                                        (dat_in & w_wmask);
            end

            if (w_wr_core && (w_reg_sel == c_ADR_CTRL)) begin
                if (sel_in[0]) begin
                    r_char_len <= dat_in[CHAR_LEN_W-1:0];
                end
                if (sel_in[1]) begin
                    r_rx_neg <= dat_in[9];
                    r_tx_neg <= dat_in[10];
                    r_lsb    <= dat_in[11];
                    r_ie     <= dat_in[12];
                    r_ass    <= dat_in[13];
                end
            end

            if (w_wr_core && (w_reg_sel == c_ADR_DIV)) begin
                r_div <= (r_div & ~w_wmask[15:0]) | (dat_in[15:0] & w_wmask[15:0]);
            end

            if (w_wr_ss) begin
                r_ss <= (r_ss & ~w_wmask[SS_W-1:0]) | (dat_in[SS_W-1:0] & w_wmask[SS_W-1:0]);
            end

            // GO is sticky until the engine reports completion; writing 0
            // to it has no effect.
            if (w_go_set) begin
                r_go_bit <= 1'b1;
            end else if (done_in) begin
                r_go_bit <= 1'b0;
            end

            // The start pulse is delayed by one stage so that it appears in
            // the cycle after the accepting write's acknowledge.
            r_go_req   <= w_go_set;
            r_go_pulse <= r_go_req;

            // Completion outranks an access clearing the interrupt.
            if (done_in && r_ie) begin
                r_int <= 1'b1;
            end else if (w_accept) begin
                r_int <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign dat_o      = r_dat;
    assign ack_o      = r_ack;
    assign int_o      = r_int;
    assign tx_data_o  = r_tx;
    assign char_len_o = r_char_len;
    assign rx_neg_o   = r_rx_neg;
    assign tx_neg_o   = r_tx_neg;
    assign lsb_o      = r_lsb;
    assign ass_o      = r_ass;
    assign divider_o  = r_div;
    assign ss_o       = r_ss;
    assign go_o       = r_go_pulse;

`ifdef SPI_WB_ERR_EN
    assign err_o = r_err;
`else
    // r_err can never be set in this build; drive the port as a constant.
    assign err_o = 1'b0 & r_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_wb_slave_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_wb_slave_regs
// Purpose  : Self-checking bench for spi_wb_slave_regs. Table-driven bus
//            accesses with a scoreboard queue of expected terminations, plus
//            hand-written sequences for GO/done, interrupt priority, abort,
//            held strobe and asynchronous reset. Honours SPI_WB_ERR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_wb_slave_regs;

`ifdef SPI_WB_ERR_EN
    localparam logic c_ERR = 1'b1;
`else
    localparam logic c_ERR = 1'b0;
`endif

    logic         clk_in = 1'b0;
    logic         rst_n_in = 1'b0;
    logic [4:0]   adr_in = '0;
    logic [31:0]  dat_in = '0;
    logic [3:0]   sel_in = '0;
    logic         we_in = 1'b0;
    logic         cyc_in = 1'b0;
    logic         stb_in = 1'b0;
    logic [31:0]  dat_o;
    logic         ack_o;
    logic         err_o;
    logic         int_o;
    logic [127:0] tx_data_o;
    logic [6:0]   char_len_o;
    logic         rx_neg_o;
    logic         tx_neg_o;
    logic         lsb_o;
    logic         ass_o;
    logic [15:0]  divider_o;
    logic [7:0]   ss_o;
    logic         go_o;
    logic         busy_in = 1'b0;
    logic         done_in = 1'b0;
    logic [127:0] rx_data_in = '0;

    spi_wb_slave_regs #(.CHAR_LEN_W(7), .SS_W(8)) dut (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .adr_in     (adr_in),
        .dat_in     (dat_in),
        .sel_in     (sel_in),
        .we_in      (we_in),
        .cyc_in     (cyc_in),
        .stb_in     (stb_in),
        .dat_o      (dat_o),
        .ack_o      (ack_o),
        .err_o      (err_o),
        .int_o      (int_o),
        .tx_data_o  (tx_data_o),
        .char_len_o (char_len_o),
        .rx_neg_o   (rx_neg_o),
        .tx_neg_o   (tx_neg_o),
        .lsb_o      (lsb_o),
        .ass_o      (ass_o),
        .divider_o  (divider_o),
        .ss_o       (ss_o),
        .go_o       (go_o),
        .busy_in    (busy_in),
        .done_in    (done_in),
        .rx_data_in (rx_data_in)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic         is_err;
        logic         chk_dat;
        logic [31:0]  dat;
    } exp_t;

    typedef struct {
        logic         we;
        logic [4:0]   adr;
        logic [31:0]  dat;
        logic [3:0]   sel;
        logic         busy;
        logic [127:0] rx;
        exp_t         exp;
    } vec_t;

    exp_t sb_q[$];
    vec_t vt[18];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [4:0] adr, input logic [31:0] dat,
                                input logic [3:0] sel, input logic busy, input logic [127:0] rx,
                                input logic is_err, input logic chk_dat, input logic [31:0] edat);
        vec_t v;
        v.we = we; v.adr = adr; v.dat = dat; v.sel = sel; v.busy = busy; v.rx = rx;
        v.exp.is_err = is_err; v.exp.chk_dat = chk_dat; v.exp.dat = edat;
        return v;
    endfunction

    // One Wishbone access: the expectation is queued when the request is
    // driven and consumed when the DUT terminates the cycle.
    task automatic wb_access(input logic we, input logic [4:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel, input exp_t e_in);
        int   lat;
        bit   seen;
        exp_t e;
        @(posedge clk_in); #1;
        sb_q.push_back(e_in);
        we_in = we; adr_in = adr; dat_in = dat; sel_in = sel;
        cyc_in = 1'b1; stb_in = 1'b1;
        lat = 0; seen = 1'b0;
        while (!seen && lat < 8) begin
            @(posedge clk_in); #1;
            lat++;
            if (ack_o || err_o) seen = 1'b1;
        end
        e = sb_q.pop_front();
        if (!seen) begin
            checks++; errors++;
            $display("FAIL term_timeout: got none expected termination at adr %h", adr);
        end else begin
            chk("term_latency", lat, 1);
            chk("term_err", {31'b0, err_o}, {31'b0, e.is_err});
            chk("term_ack", {31'b0, ack_o}, {31'b0, ~e.is_err});
            if (e.chk_dat) chk("read_data", dat_o, e.dat);
        end
        cyc_in = 1'b0; stb_in = 1'b0; we_in = 1'b0;
        @(posedge clk_in); #1;
        chk("term_one_cycle", {30'b0, ack_o, err_o}, 32'h0);
        chk("dat_idle_zero", dat_o, 32'h0);
    endtask

    function automatic exp_t ex(input logic is_err, input logic chk_dat, input logic [31:0] d);
        exp_t e;
        e.is_err = is_err; e.chk_dat = chk_dat; e.dat = d;
        return e;
    endfunction

    initial begin
        logic [127:0] rx3;
        int           ackcnt;
        rx3 = '0;
        rx3[127:96] = 32'h0123_4567;

        vt[0]  = mk(1, 5'h00, 32'hA5A5_0001, 4'b0011, 0, '0, 0, 0, 0);
        vt[1]  = mk(0, 5'h00, 32'h0, 4'b0000, 0, {96'h0, 32'hDEAD_BEEF}, 0, 1, 32'hDEAD_BEEF);
        vt[2]  = mk(1, 5'h04, 32'h1234_5678, 4'b1111, 0, '0, 0, 0, 0);
        vt[3]  = mk(1, 5'h08, 32'hFFFF_FFFF, 4'b1000, 0, '0, 0, 0, 0);
        vt[4]  = mk(1, 5'h14, 32'h0000_ABCD, 4'b0011, 0, '0, 0, 0, 0);
        vt[5]  = mk(0, 5'h14, 32'h0, 4'b0000, 0, '0, 0, 1, 32'h0000_ABCD);
        vt[6]  = mk(1, 5'h18, 32'h0000_00A5, 4'b0001, 0, '0, 0, 0, 0);
        vt[7]  = mk(0, 5'h18, 32'h0, 4'b0000, 0, '0, 0, 1, 32'h0000_00A5);
        vt[8]  = mk(0, 5'h0C, 32'h0, 4'b0000, 0, rx3, 0, 1, 32'h0123_4567);
        vt[9]  = mk(1, 5'h10, 32'h0000_2E07, 4'b0011, 0, '0, 0, 0, 0);
        vt[10] = mk(0, 5'h10, 32'h0, 4'b0000, 0, '0, 0, 1, 32'h0000_2E07);
        vt[11] = mk(0, 5'h1C, 32'h0, 4'b0000, 0, '0, c_ERR, 1, 32'h0);
        vt[12] = mk(1, 5'h14, 32'h0000_0010, 4'b0011, 1, '0, c_ERR, 0, 0);
        vt[13] = mk(0, 5'h14, 32'h0, 4'b0000, 1, '0, 0, 1, 32'h0000_ABCD);
        vt[14] = mk(1, 5'h18, 32'h0000_0003, 4'b0001, 1, '0, 0, 0, 0);
        vt[15] = mk(0, 5'h18, 32'h0, 4'b0000, 0, '0, 0, 1, 32'h0000_0003);
        vt[16] = mk(1, 5'h1C, 32'hFFFF_FFFF, 4'b1111, 0, '0, c_ERR, 0, 0);
        vt[17] = mk(0, 5'h17, 32'h0, 4'b0000, 0, '0, 0, 1, 32'h0000_ABCD);

        // Reset state
        #12;
        chk("rst_ack_err_int_go", {28'b0, ack_o, err_o, int_o, go_o}, 32'h0);
        chk("rst_dat", dat_o, 32'h0);
        chk("rst_tx0", tx_data_o[31:0], 32'h0);
        chk("rst_div_ss", {8'h0, divider_o, ss_o}, 32'h0);
        @(negedge clk_in);
        rst_n_in = 1'b1;

        for (int i = 0; i < 18; i++) begin
            busy_in    = vt[i].busy;
            rx_data_in = vt[i].rx;
            wb_access(vt[i].we, vt[i].adr, vt[i].dat, vt[i].sel, vt[i].exp);
        end
        busy_in = 1'b0;

        chk("tx0", tx_data_o[31:0], 32'h0000_0001);
        chk("tx1", tx_data_o[63:32], 32'h1234_5678);
        chk("tx2", tx_data_o[95:64], 32'hFF00_0000);
        chk("tx3", tx_data_o[127:96], 32'h0);
        chk("divider", {16'h0, divider_o}, 32'h0000_ABCD);
        chk("ss", {24'h0, ss_o}, 32'h3);
        chk("char_len", {25'h0, char_len_o}, 32'h7);
        chk("ctrl_flags", {28'h0, ass_o, lsb_o, tx_neg_o, rx_neg_o}, 32'hF);
        chk("no_go_int", {30'h0, go_o, int_o}, 32'h0);

        // GO / done / interrupt
        wb_access(1, 5'h10, 32'h0000_1108, 4'b0011, ex(0, 0, 0));
        chk("go_pulse_high", {31'h0, go_o}, 32'h1);
        @(posedge clk_in); #1;
        chk("go_pulse_low", {31'h0, go_o}, 32'h0);
        wb_access(0, 5'h10, 32'h0, 4'b0000, ex(0, 1, 32'h0000_1108));
        chk("char_len_8", {25'h0, char_len_o}, 32'h8);
        done_in = 1'b1;
        @(posedge clk_in); #1;
        done_in = 1'b0;
        chk("int_set", {31'h0, int_o}, 32'h1);
        wb_access(0, 5'h14, 32'h0, 4'b0000, ex(0, 1, 32'h0000_ABCD));
        chk("int_clear", {31'h0, int_o}, 32'h0);
        wb_access(0, 5'h10, 32'h0, 4'b0000, ex(0, 1, 32'h0000_1008));

        // done_in coinciding with an accepted access: set wins
        @(posedge clk_in); #1;
        sb_q.push_back(ex(0, 1, 32'h0000_ABCD));
        we_in = 1'b0; adr_in = 5'h14; cyc_in = 1'b1; stb_in = 1'b1; done_in = 1'b1;
        @(posedge clk_in); #1;
        done_in = 1'b0;
        cyc_in = 1'b0; stb_in = 1'b0;
        begin
            exp_t e;
            e = sb_q.pop_front();
            chk("coincide_ack", {31'h0, ack_o}, {31'h0, ~e.is_err});
            chk("coincide_dat", dat_o, e.dat);
        end
        chk("coincide_int_set", {31'h0, int_o}, 32'h1);
        wb_access(0, 5'h18, 32'h0, 4'b0000, ex(0, 1, 32'h3));
        chk("int_clear2", {31'h0, int_o}, 32'h0);

        // GO write while busy is ignored
        busy_in = 1'b1;
        wb_access(1, 5'h10, 32'h0000_0100, 4'b0011, ex(c_ERR, 0, 0));
        chk("busy_go_none", {31'h0, go_o}, 32'h0);
        busy_in = 1'b0;
        wb_access(0, 5'h10, 32'h0, 4'b0000, ex(0, 1, 32'h0000_1008));

        // Abort: cyc dropped before the accepting edge
        @(posedge clk_in); #1;
        we_in = 1'b1; adr_in = 5'h04; dat_in = 32'h0000_1234; sel_in = 4'b1111;
        cyc_in = 1'b1; stb_in = 1'b1;
        #3;
        cyc_in = 1'b0; stb_in = 1'b0;
        ackcnt = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_in); #1;
            if (ack_o || err_o) ackcnt++;
        end
        we_in = 1'b0;
        chk("abort_no_term", ackcnt, 0);
        chk("abort_tx1", tx_data_o[63:32], 32'h1234_5678);

        // Held strobe: terminations every second cycle
        @(posedge clk_in); #1;
        we_in = 1'b0; adr_in = 5'h14; cyc_in = 1'b1; stb_in = 1'b1;
        @(posedge clk_in); #1;
        chk("held_ack1", {31'h0, ack_o}, 32'h1);
        @(posedge clk_in); #1;
        chk("held_gap", {31'h0, ack_o}, 32'h0);
        @(posedge clk_in); #1;
        chk("held_ack2", {31'h0, ack_o}, 32'h1);
        cyc_in = 1'b0; stb_in = 1'b0;
        @(posedge clk_in); #1;

        // Asynchronous reset in the middle of a read acknowledge
        rx_data_in = {96'h0, 32'hDEAD_BEEF};
        adr_in = 5'h00; cyc_in = 1'b1; stb_in = 1'b1;
        @(posedge clk_in); #1;
        chk("pre_rst_dat", dat_o, 32'hDEAD_BEEF);
        #1;
        rst_n_in = 1'b0;
        #1;
        chk("async_rst_ack_err_int_go", {28'b0, ack_o, err_o, int_o, go_o}, 32'h0);
        chk("async_rst_dat", dat_o, 32'h0);
        chk("async_rst_tx", tx_data_o[63:32] | tx_data_o[31:0], 32'h0);
        chk("async_rst_div_ss", {8'h0, divider_o, ss_o}, 32'h0);
        chk("async_rst_ctrl", {24'h0, ass_o, char_len_o}, 32'h0);
        cyc_in = 1'b0; stb_in = 1'b0;
        @(negedge clk_in);
        rst_n_in = 1'b1;
        repeat (2) @(posedge clk_in);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
